// File: rtl/seg7_readback_3.sv
// Display-side monitor for a 3-digit 7-segment counter: debounces the segment buses, decodes to BCD/value,
// and (with SEG_READBACK_SEQ_CHECK_EN defined) checks the count+1 / 999->000 sequence.
module seg7_readback_3 #(
    parameter int STABLE_CYCLES = 4,
    parameter int ERR_CNT_W     = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [7:0]           seg0,
    input  logic [7:0]           seg1,
    input  logic [7:0]           seg2,
    input  logic                 resync,
    output logic [3:0]           bcd0,
    output logic [3:0]           bcd1,
    output logic [3:0]           bcd2,
    output logic [9:0]           value,
    output logic                 val_valid,
    output logic                 dec_err,
    output logic                 seq_err,
    output logic                 locked,
    output logic [ERR_CNT_W-1:0] err_cnt
);
    localparam int            CW        = (STABLE_CYCLES > 1) ? $clog2(STABLE_CYCLES) : 1;
    localparam logic [CW-1:0] STAB_LAST = CW'(STABLE_CYCLES - 1);

    typedef enum logic [1:0] {S_WAIT, S_SETTLE, S_STABLE} state_t;

    state_t        state, state_d;
    logic [23:0]   seg_q, cand, cand_d;
    logic [CW-1:0] stab_cnt, stab_d;
    logic          accept;

    // Returns {valid, digit}; bits [7:1] of a bus are a..g, dp is dropped by the caller.
    function automatic logic [4:0] decode(input logic [6:0] s);
        case (s)
            7'b1111110: decode = 5'h10;
            7'b0110000: decode = 5'h11;
            7'b1101101: decode = 5'h12;
            7'b1111001: decode = 5'h13;
            7'b0110011: decode = 5'h14;
            7'b1011011: decode = 5'h15;
            7'b1011111: decode = 5'h16;
            7'b1110000: decode = 5'h17;
            7'b1111111: decode = 5'h18;
            7'b1110011: decode = 5'h19;
            default:    decode = 5'h00;
        endcase
    endfunction

    logic [4:0] d0, d1, d2;
    logic       all_valid;
    logic [9:0] val_new;
    logic       seq_bad;

    assign d0        = decode(cand[7:1]);
    assign d1        = decode(cand[15:9]);
    assign d2        = decode(cand[23:17]);
    assign all_valid = d0[4] & d1[4] & d2[4];
    assign val_new   = 10'(d2[3:0]) * 10'd100 + 10'(d1[3:0]) * 10'd10 + 10'(d0[3:0]);
    assign locked    = (state == S_STABLE);

    always_comb begin
        state_d = state;
        cand_d  = cand;
        stab_d  = stab_cnt;
        accept  = 1'b0;
        case (state)
            S_WAIT: begin
                if (seg_q != cand) begin
                    cand_d  = seg_q;
                    stab_d  = '0;
                    state_d = S_SETTLE;
                end
            end
            S_SETTLE: begin
                if (seg_q != cand) begin
                    cand_d = seg_q;
                    stab_d = '0;
                end else if (stab_cnt == STAB_LAST) begin
                    accept  = 1'b1;
                    state_d = S_STABLE;
                end else begin
                    stab_d = stab_cnt + 1'b1;
                end
            end
            S_STABLE: begin
                if (seg_q != cand) begin
                    cand_d  = seg_q;
                    stab_d  = '0;
                    state_d = S_SETTLE;
                end
            end
            default: state_d = S_WAIT;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= S_WAIT;
            seg_q    <= '0;
            cand     <= '0;
            stab_cnt <= '0;
        end else begin
            state    <= state_d;
            seg_q    <= {seg2, seg1, seg0};
            cand     <= cand_d;
            stab_cnt <= stab_d;
        end
    end

`ifdef SEG_READBACK_SEQ_CHECK_EN
    logic       have_prev;
    logic [9:0] prev;
    logic [9:0] expected;

    assign expected = (prev == 10'd999) ? 10'd0 : prev + 10'd1;
    // resync on the same edge as an accept suppresses the check for that accept
    assign seq_bad  = have_prev && !resync && (val_new != prev) && (val_new != expected);

    always_ff @(posedge clk) begin
        if (rst) begin
            have_prev <= 1'b0;
            prev      <= '0;
        end else begin
            if (resync)
                have_prev <= 1'b0;
            if (accept && all_valid) begin
                have_prev <= 1'b1;
                prev      <= val_new;
            end
        end
    end
`else
    logic unused_resync;
    assign unused_resync = resync;
    assign seq_bad       = 1'b0;
`endif

    logic err_pulse;
    assign err_pulse = accept && (!all_valid || seq_bad);

    always_ff @(posedge clk) begin
        if (rst) begin
            bcd0      <= '0;
            bcd1      <= '0;
            bcd2      <= '0;
            value     <= '0;
            val_valid <= 1'b0;
            dec_err   <= 1'b0;
            seq_err   <= 1'b0;
            err_cnt   <= '0;
        end else begin
            val_valid <= accept && all_valid;
            dec_err   <= accept && !all_valid;
            seq_err   <= accept && all_valid && seq_bad;
            if (accept && all_valid) begin
                bcd0  <= d0[3:0];
                bcd1  <= d1[3:0];
                bcd2  <= d2[3:0];
                value <= val_new;
            end
            if (err_pulse && (err_cnt != '1))
                err_cnt <= err_cnt + 1'b1;
        end
    end
endmodule
